// File: rtl/alu_issue_if.sv
// Request/response channels between decode/issue logic and the alu_issue front-end.
// The master drives requests and consumes responses; the slave is the front-end.
interface alu_issue_if #(
    parameter int TAGW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [1:0]      req_op;
    logic [TAGW-1:0] req_tag;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [3:0]      rsp_flags;
    logic [TAGW-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_flags, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_flags, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Two-stage issue front-end for a combinational ALU: registers operands into the ALU,
// captures the settled result into a tagged result FIFO, and tracks sticky overflow.
module alu_issue #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_neg,
    output logic        ovf_sticky,
    input  logic        clr_ovf,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [31:0]     data;
        logic [3:0]      flags;
        logic [TAGW-1:0] tag;
    } entry_t;

    logic            vld_p1;
    logic [TAGW-1:0] tag_p1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occ;

    logic            accept;
    logic            push;
    logic            pop;
    entry_t          push_ent;
    entry_t          head;

    // Only add (00) and sub (10) produce meaningful carry/overflow.
    function automatic logic [3:0] mk_flags(input logic [1:0] op, input logic n,
                                            input logic z, input logic v, input logic c);
        logic arith;
        arith = ~op[0];
        return {n, z, v & arith, c & arith};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign push   = vld_p1;
    assign pop    = bus.rsp_valid && bus.rsp_ready;
    // Room is counted over everything in flight, including the op still in the ALU.
    assign occ    = {1'b0, count} + OW'(vld_p1) - OW'(pop);
    assign bus.req_ready = (occ < OW'(DEPTH));
    assign accept = bus.req_valid && bus.req_ready;

    assign push_ent = '{data:  alu_out,
                        flags: mk_flags(alu_ctrl, alu_neg, alu_zero, alu_ovf, alu_carry),
                        tag:   tag_p1};

    // ISSUE stage -> p1: operands held at the ALU inputs while it settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            tag_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                alu_a    <= bus.req_a;
                alu_b    <= bus.req_b;
                alu_ctrl <= bus.req_op;
                tag_p1   <= bus.req_tag;
            end
        end
    end

    // EXEC stage -> FIFO: settled ALU result captured at the end of the exec cycle
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (push && push_ent.flags[1])
            ovf_sticky <= 1'b1;
        else if (clr_ovf)
            ovf_sticky <= 1'b0;
    end

    // Response fields read zero whenever nothing is presented.
    assign head          = mem[rd_ptr];
    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_data  = bus.rsp_valid ? head.data  : '0;
    assign bus.rsp_flags = bus.rsp_valid ? head.flags : '0;
    assign bus.rsp_tag   = bus.rsp_valid ? head.tag   : '0;

    assign busy = vld_p1 || bus.rsp_valid;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and randomized bench for alu_issue with a behavioural ALU and a
// queue-based reference model of outstanding operations.
module tb_alu_issue;

    localparam int DEPTH = 2;
    localparam int TAGW  = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_ctrl;
    logic        alu_carry, alu_zero, alu_ovf, alu_neg;
    logic        ovf_sticky, clr_ovf, busy;

    alu_issue_if #(.TAGW(TAGW)) bus ();

    alu_issue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_neg(alu_neg),
        .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: subtraction and slt share an adder with inverted B.
    logic [32:0] s33;
    logic [31:0] bb;
    always_comb begin
        bb        = alu_ctrl[1] ? ~alu_b : alu_b;
        s33       = {1'b0, alu_a} + {1'b0, bb} + {32'b0, alu_ctrl[1]};
        alu_carry = s33[32];
        alu_ovf   = (alu_a[31] == bb[31]) && (s33[31] != alu_a[31]);
        case (alu_ctrl)
            2'b01:   alu_out = alu_a ^ alu_b;
            2'b11:   alu_out = {31'b0, s33[31] ^ alu_ovf};
            default: alu_out = s33[31:0];
        endcase
        alu_zero = (alu_out == 32'b0);
        alu_neg  = alu_out[31];
    end

    typedef struct {
        logic [31:0]     d;
        logic [3:0]      f;
        logic [TAGW-1:0] t;
        int              avail;
    } ent_t;

    ent_t            q[$];
    int              pop_tags[$];
    int              pop_cycs[$];
    int              cyc, passed, total, acc_cnt;
    int              last_acc_cyc, last_pop_cyc;
    bit              sticky_m, last_acc;
    logic [31:0]     last_d;
    logic [3:0]      last_f;
    logic [TAGW-1:0] last_t;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    function automatic ent_t ref_op(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [TAGW-1:0] tag);
        ent_t e;
        longint sa, sb, r;
        longint unsigned ua, ub;
        logic v, c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        v = 1'b0;
        c = 1'b0;
        r = 0;
        case (op)
            2'b00: begin
                r = sa + sb;
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                c = (ua + ub) > 64'hFFFF_FFFF;
            end
            2'b01: r = longint'(a ^ b);
            2'b10: begin
                r = sa - sb;
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                c = (ua >= ub);
            end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        e.d = r[31:0];
        e.f = {e.d[31], e.d == 32'b0, v, c};
        e.t = tag;
        e.avail = 0;
        return e;
    endfunction

    // One clock: called at a falling edge with inputs already driven.
    task automatic step();
        logic exp_v, exp_rdy, pop_m, push_v;
        ent_t e;
        int sz;
        #4;
        sz      = q.size();
        exp_v   = (sz > 0) && (q[0].avail <= cyc);
        pop_m   = exp_v && bus.rsp_ready;
        exp_rdy = ((sz - (pop_m ? 1 : 0)) < DEPTH);
        chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_v});
        chk("rsp_data", bus.rsp_data, exp_v ? q[0].d : 32'b0);
        chk("rsp_flags", {28'b0, bus.rsp_flags}, exp_v ? {28'b0, q[0].f} : 32'b0);
        chk("rsp_tag", 32'(bus.rsp_tag), exp_v ? 32'(q[0].t) : 32'b0);
        chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_rdy});
        chk("busy", {31'b0, busy}, {31'b0, sz > 0});
        chk("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, sticky_m});
        chk("no_push_full", {31'b0, dut.vld_p1 && (dut.count == DEPTH) && !pop_m}, 32'b0);
        push_v = 1'b0;
        foreach (q[i]) if (q[i].avail == cyc + 1 && q[i].f[1]) push_v = 1'b1;
        if (push_v) sticky_m = 1'b1;
        else if (clr_ovf) sticky_m = 1'b0;
        if (pop_m) begin
            last_d = bus.rsp_data;
            last_f = bus.rsp_flags;
            last_t = bus.rsp_tag;
            last_pop_cyc = cyc;
            pop_tags.push_back(int'(bus.rsp_tag));
            pop_cycs.push_back(cyc);
            void'(q.pop_front());
        end
        last_acc = bus.req_valid && exp_rdy;
        if (last_acc) begin
            e = ref_op(bus.req_op, bus.req_a, bus.req_b, bus.req_tag);
            e.avail = cyc + 2;
            q.push_back(e);
            acc_cnt = acc_cnt + 1;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAGW-1:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAGW-1:0] tag);
        int n;
        set_req(op, a, b, tag);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        bus.req_valid = 1'b0;
        if (!last_acc) chk("issue_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAGW-1:0] tag,
                           input logic [31:0] ed, input logic [3:0] ef);
        issue(op, a, b, tag);
        drain(3);
        chk({name, "_data"}, last_d, ed);
        chk({name, "_flags"}, {28'b0, last_f}, {28'b0, ef});
        chk({name, "_tag"}, 32'(last_t), 32'(tag));
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        passed = 0; total = 0; cyc = 0; acc_cnt = 0; sticky_m = 1'b0; last_acc = 1'b0;
        last_acc_cyc = 0; last_pop_cyc = 0;
        rst_n = 1'b0; clr_ovf = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_alu_a", alu_a, 32'b0);
        chk("rst_alu_b", alu_b, 32'b0);
        chk("rst_alu_ctrl", {30'b0, alu_ctrl}, 32'b0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'b0);
        chk("rst_busy", {31'b0, busy}, 32'b0);
        chk("rst_sticky", {31'b0, ovf_sticky}, 32'b0);
        rst_n = 1'b1;

        // Basic add, latency of two edges from accept to response
        bus.rsp_ready = 1'b1;
        run_one("t1_add", 2'b00, 32'h0000_0DEF, 32'h0000_0ABC, 4'd3, 32'h0000_18AB, 4'b0000);
        chk("t1_latency", 32'(last_pop_cyc - last_acc_cyc), 32'd2);

        // Signed overflow and sticky status
        run_one("t2_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd4, 32'h8000_0000, 4'b1010);
        chk("t2_sticky_set", {31'b0, ovf_sticky}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t2_sticky_clr", {31'b0, ovf_sticky}, 32'd0);
        clr_ovf = 1'b1;
        issue(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd5);
        step();
        clr_ovf = 1'b0;
        chk("t2_set_wins", {31'b0, ovf_sticky}, 32'd1);
        drain(2);

        run_one("t3_sub_ovf", 2'b10, 32'h8000_0000, 32'h0000_0001, 4'd6, 32'h7FFF_FFFF, 4'b0011);
        run_one("t3_sub_zero", 2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd7, 32'h0000_0000, 4'b0101);
        run_one("t4_slt", 2'b11, 32'h0000_0000, 32'h0000_0001, 4'd1, 32'h0000_0001, 4'b0000);
        run_one("t4_xor", 2'b01, 32'h0000_1234, 32'h0000_0105, 4'd2, 32'h0000_1331, 4'b0000);

        // Back-pressure: only DEPTH ops fit while the consumer stalls
        bus.rsp_ready = 1'b0;
        acc_cnt = 0; k = 0;
        set_req(2'b00, $urandom, $urandom, 4'd8);
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_acc) begin
                k++;
                if (k < 4) set_req(2'b01, $urandom, $urandom, TAGW'(8 + k));
                else bus.req_valid = 1'b0;
            end
        end
        chk("t5_accepted", 32'(acc_cnt), 32'd2);
        chk("t5_req_ready_low", {31'b0, bus.req_ready}, 32'd0);
        pop_tags.delete();
        pop_cycs.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_acc) begin
                k++;
                if (k < 4) set_req(2'b01, $urandom, $urandom, TAGW'(8 + k));
                else bus.req_valid = 1'b0;
            end
        end
        chk("t5_pop_count", 32'(pop_tags.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_tags.size(); i++)
            chk("t5_tag_order", 32'(pop_tags[i]), 32'(8 + i));
        for (int i = 1; i < pop_cycs.size(); i++)
            chk("t5_rate", 32'(pop_cycs[i] - pop_cycs[i-1]), 32'd1);

        // Asynchronous reset with one op in the ALU and one in the FIFO
        bus.rsp_ready = 1'b0;
        issue(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1);
        set_req(2'b10, 32'h0000_0010, 32'h0000_0003, 4'd2);
        step();
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_alu_a", alu_a, 32'b0);
        chk("t6_alu_b", alu_b, 32'b0);
        chk("t6_alu_ctrl", {30'b0, alu_ctrl}, 32'b0);
        chk("t6_rsp_valid", {31'b0, bus.rsp_valid}, 32'b0);
        chk("t6_rsp_data", bus.rsp_data, 32'b0);
        chk("t6_rsp_flags", {28'b0, bus.rsp_flags}, 32'b0);
        chk("t6_rsp_tag", 32'(bus.rsp_tag), 32'b0);
        chk("t6_busy", {31'b0, busy}, 32'b0);
        chk("t6_sticky", {31'b0, ovf_sticky}, 32'b0);
        q.delete();
        sticky_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        pop_tags.delete();
        drain(5);
        chk("t6_no_stale", 32'(pop_tags.size()), 32'd0);

        // Randomized traffic against the reference model
        last_acc = 1'b0;
        pop_tags.delete();
        pop_cycs.delete();
        for (int i = 0; i < 400; i++) begin
            if (!bus.req_valid || last_acc) begin
                if ($urandom_range(0, 9) < 7)
                    set_req(2'($urandom_range(0, 3)), pick32(), pick32(), TAGW'($urandom));
                else
                    bus.req_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        clr_ovf = 1'b0;
        drain(6);
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Sequential request/response front-end that owns one combinational `alu` instance: it drives the ALU's BussA/BussB/ALUControl and captures Output plus the carry, zero, overflow and negative flags.
- It accepts operation requests over a valid/ready handshake, registers the operands into the ALU, and captures the result one cycle later into a result FIFO.
- It returns results with a tag over a second valid/ready handshake and keeps a sticky overflow status.
- It sits between the core's decode/issue logic and the datapath ALU.

Parameters:
DEPTH, 2, result FIFO entries; legal values 2..8. DEPTH=2 gives full throughput.
TAGW, 4, width of the request/response tag.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request can be accepted this cycle
req_a  input  32  operand A
req_b  input  32  operand B
req_op  input  2  00 add, 01 xor, 10 sub, 11 set-less-than
req_tag  input  TAGW  tag returned with the result
alu_a  output  32  to ALU BussA (registered)
alu_b  output  32  to ALU BussB (registered)
alu_ctrl  output  2  to ALU ALUControl (registered)
alu_out  input  32  from ALU Output
alu_carry  input  1  from ALU CarryOut
alu_zero  input  1  from ALU zero
alu_ovf  input  1  from ALU overflow
alu_neg  input  1  from ALU negative
rsp_valid  output  1  FIFO head valid
rsp_ready  input  1  consumer accepts head
rsp_data  output  32  result
rsp_flags  output  4  {N,Z,V,C} of result
rsp_tag  output  TAGW  tag of result
ovf_sticky  output  1  set by any captured V=1
clr_ovf  input  1  clears ovf_sticky
busy  output  1  exec stage valid or FIFO non-empty

Behaviour:
Reset (rst_n low, async):
- alu_a, alu_b, alu_ctrl, exec_v, FIFO pointers and count, and ovf_sticky all go to 0.
- rsp_valid=0, busy=0. rsp_data/rsp_flags/rsp_tag read 0.
- Reset mid-operation discards the in-flight op and all FIFO contents; no response is produced for them.

Handshake:
- Transfer occurs on an edge where valid && ready are both high.
- Requester holds req_* stable while req_valid is high and req_ready is low.
- Consumer sees rsp_* stable while rsp_valid is high and rsp_ready is low.

Pipeline (two stages):
- ISSUE: on accept at edge T, alu_a/alu_b/alu_ctrl/exec_tag load from req_*, and exec_v<=1.
- EXEC: during cycle T..T+1 the ALU settles. At edge T+1, if exec_v=1, {alu_out, flags, exec_tag} is pushed to the FIFO. exec_v then clears unless a new request is accepted at the same edge.
- Latency: rsp_valid is high the cycle after edge T+1, i.e. 2 edges after accept.

Flow control:
- pop = rsp_valid && rsp_ready.
- req_ready = (count + exec_v - pop) < DEPTH. This is a combinational path from rsp_ready to req_ready (intended).
- A push never occurs into a full FIFO by construction; the bench asserts this.

Flags: N = alu_neg, Z = alu_zero. V and C depend on the op:
- op 00 or 10: V = alu_ovf, C = alu_carry.
- op 01 or 11: V = 0, C = 0.

Sticky overflow: ovf_sticky is set on a push with V=1. If clr_ovf is high on the same edge, set wins.

FIFO:
- Circular, with wrap-around of read/write pointers mod DEPTH.
- Simultaneous push and pop on full or empty is legal; count is unchanged on a simultaneous push+pop.
- Empty: rsp_valid=0. Full and no pop: req_ready=0.

Test Plan:
1. add A=00000DEF B=00000ABC tag=3 -> rsp_data=000018AB, flags=0000, tag=3, rsp_valid 2 edges after accept.
2. add 7FFFFFFF+00000001 -> 80000000, flags=1010, ovf_sticky=1. Then clr_ovf -> ovf_sticky=0. clr_ovf together with another V=1 push -> stays 1.
3. sub 80000000-00000001 -> 7FFFFFFF, flags=0011. sub 7FFFFFFF-7FFFFFFF -> 00000000, flags=0101.
4. slt A=0 B=1 -> 00000001, flags=0000. xor 00001234^00000105 -> 00001331, flags=0000.
5. Back-pressure: rsp_ready=0, issue 4 back-to-back requests with DEPTH=2. Exactly 2 are accepted and req_ready drops. Release rsp_ready -> tags return in order with no loss or duplication; with rsp_ready=1 steady, 1 result per cycle.
6. Assert rst_n low with exec_v=1 and FIFO holding 1 entry -> all outputs 0 immediately. After release, no stale response appears.
